alu_operand_sequencer: RTL

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_sequencer
//  Description : Collects operand A, operand B and an opcode from one shared
//                data bus. Each field loads on a rising edge of its own level
//                request. When all three fields are loaded, the operand set is
//                presented to a downstream ALU with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MODE_WIDTH = 6,
  localparam int BUS_WIDTH  = (DATA_WIDTH > MODE_WIDTH) ? DATA_WIDTH : MODE_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic signed [BUS_WIDTH-1:0]  i_data_bus,
  input  logic                         i_load_A,
  input  logic                         i_load_B,
  input  logic                         i_load_op,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_A,
  output logic signed [DATA_WIDTH-1:0] o_B,
  output logic        [MODE_WIDTH-1:0] o_mode,
  output logic                         o_valid,
  output logic        [2:0]            o_loaded
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ld_prev_q, ld_prev_d;  // {op, B, A} previous samples
  logic [2:0]             loaded_q, loaded_d;    // {op, B, A} loaded flags
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [MODE_WIDTH-1:0]  mode_q, mode_d;

  logic [2:0]             ld_now;
  logic [2:0]             ld_edge;
  logic [2:0]             ld_win;

  assign ld_now = {i_load_op, i_load_B, i_load_A};

  // Rising-edge detect per request, then one-hot priority A > B > op;
  // losing edges are simply dropped.
  always_comb begin
    ld_edge   = ld_now & ~ld_prev_q;
    ld_win    = 3'b000;
    if (ld_edge[0]) begin
      ld_win = 3'b001;
    end else if (ld_edge[1]) begin
      ld_win = 3'b010;
    end else if (ld_edge[2]) begin
      ld_win = 3'b100;
    end
  end

  // Next-state, register capture and loaded-flag bookkeeping.
  always_comb begin
    state_d   = state_q;
    loaded_d  = loaded_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    ld_prev_d = ld_now;

    if (ld_win[0]) a_d    = i_data_bus[DATA_WIDTH-1:0];
    if (ld_win[1]) b_d    = i_data_bus[DATA_WIDTH-1:0];
    if (ld_win[2]) mode_d = i_data_bus[MODE_WIDTH-1:0];

    case (state_q)
      ST_COLLECT: begin
        // i_ready is ignored while collecting.
        loaded_d = loaded_q | ld_win;
        if (loaded_d == 3'b111) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // A consume clears the flags; a simultaneous load leaves only its bit.
        // Without a consume, loads overwrite and the flags stay all-ones.
        if (i_ready) begin
          state_d  = ST_COLLECT;
          loaded_d = ld_win;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        loaded_d = 3'b000;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_COLLECT;
      ld_prev_q <= 3'b000;
      loaded_q  <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      ld_prev_q <= ld_prev_d;
      loaded_q  <= loaded_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
    end
  end

  assign o_A      = a_q;
  assign o_B      = b_q;
  assign o_mode   = mode_q;
  assign o_loaded = loaded_q;
  assign o_valid  = (state_q == ST_FULL);

endmodule
`default_nettype wire
